// File: rtl/video_window_display.sv
// Pixel-source stage: windowed FIFO reads, format conversion to RGB888, latency
// alignment to the incoming coordinates and frame-boundary recovery from underflow.
module video_window_display #(
    parameter int          WIN_X0   = 0,
    parameter int          WIN_Y0   = 0,
    parameter int          WIN_W    = 1024,
    parameter int          WIN_H    = 720,
    parameter int          RD_LAT   = 1,
    parameter int          DATA_W   = 16,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic              pixel_de,
    input  logic [10:0]       pixel_xpos,
    input  logic [10:0]       pixel_ypos,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              rd_req,
    output logic [23:0]       pixel_data,
    output logic              frame_start,
    output logic              underflow,
    output logic [7:0]        underflow_cnt
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    // Window bounds held in 12 bits so X0+W / Y0+H cannot wrap on 11-bit coordinates.
    localparam logic [11:0] X_LO = 12'(WIN_X0);
    localparam logic [11:0] X_HI = 12'(WIN_X0 + WIN_W);
    localparam logic [11:0] Y_LO = 12'(WIN_Y0);
    localparam logic [11:0] Y_HI = 12'(WIN_Y0 + WIN_H);

    function automatic logic [23:0] convert_pixel(input logic [1:0] fmt,
                                                  input logic [DATA_W-1:0] d);
        logic [23:0] px;
        case (fmt)
            2'd1:    px = {d[7:0], d[7:0], d[7:0]};
            2'd2:    px = (|d) ? 24'hFFFFFF : 24'h000000;
            default: px = {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
        endcase
        return px;
    endfunction

    logic [11:0]   x_s;
    logic [11:0]   y_s;
    logic          in_win_s;
    logic          fs_cond_s;
    logic          fs_rise_s;
    logic          fs_prev_r;
    logic          frame_start_r;
    logic          uf_event_s;
    state_t        state_r;
    state_t        next_state_s;
    logic [1:0]    mode_q_r;
    logic          rd_req_next_s;
    logic [23:0]   pixel_next_s;
    logic          rd_req_r;
    logic [RD_LAT:0] vld_r;
    logic [23:0]   pixel_data_r;
    logic          underflow_r;
    logic [7:0]    underflow_cnt_r;

    assign x_s        = {1'b0, pixel_xpos};
    assign y_s        = {1'b0, pixel_ypos};
    assign in_win_s   = pixel_de && (x_s >= X_LO) && (x_s < X_HI)
                                 && (y_s >= Y_LO) && (y_s < Y_HI);
    assign fs_cond_s  = pixel_de && (pixel_xpos == 11'd0) && (pixel_ypos == 11'd0);
    assign fs_rise_s  = fs_cond_s && !fs_prev_r;
    assign uf_event_s = (state_r == ST_RUN) && rd_req_r && fifo_empty;

    // Frame-start edge detector and registered one-cycle pulse
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fs_prev_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            fs_prev_r     <= fs_cond_s;
            frame_start_r <= fs_rise_s;
        end
    end

    // State register
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a frame start wins over a simultaneous underflow
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_SYNC, ST_RESYNC: begin
                if (fs_rise_s) next_state_s = ST_RUN;
                else           next_state_s = state_r;
            end
            ST_RUN: begin
                if (fs_rise_s)       next_state_s = ST_RUN;
                else if (uf_event_s) next_state_s = ST_RESYNC;
                else                 next_state_s = ST_RUN;
            end
            default: next_state_s = ST_SYNC;
        endcase
    end

    // Output logic; gating on the next state lets the frame's first pixel be read
    always_comb begin
        rd_req_next_s = (next_state_s == ST_RUN) && in_win_s;
        if (vld_r[RD_LAT]) pixel_next_s = convert_pixel(mode_q_r, fifo_data);
        else               pixel_next_s = BG_COLOR;
    end

    // Format is sampled only at frame start
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q_r <= 2'd0;
        end else if (fs_rise_s) begin
            mode_q_r <= mode;
        end else begin
            mode_q_r <= mode_q_r;
        end
    end

    // Sticky underflow flag and saturating event counter
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            underflow_r     <= 1'b0;
            underflow_cnt_r <= 8'd0;
        end else if (uf_event_s) begin
            underflow_r     <= 1'b1;
            underflow_cnt_r <= (underflow_cnt_r == 8'hFF) ? 8'hFF : underflow_cnt_r + 8'd1;
        end else begin
            underflow_r     <= underflow_r;
            underflow_cnt_r <= underflow_cnt_r;
        end
    end

    // Read strobe, valid delay line and registered pixel output
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_req_r     <= 1'b0;
            vld_r        <= '0;
            pixel_data_r <= 24'h000000;
        end else begin
            rd_req_r     <= rd_req_next_s;
            vld_r        <= {vld_r[RD_LAT-1:0], rd_req_next_s};
            pixel_data_r <= pixel_next_s;
        end
    end

    assign rd_req        = rd_req_r;
    assign pixel_data    = pixel_data_r;
    assign frame_start   = frame_start_r;
    assign underflow     = underflow_r;
    assign underflow_cnt = underflow_cnt_r;

endmodule

// File: tb/tb_video_window_display.sv
// Directed bench for video_window_display on a miniature 12x4 raster
// (10x3 active) with a 4x2 window at (3,1), RD_LAT=2 and a non-zero background.
module tb_video_window_display;

    localparam int          H_TOT  = 12;
    localparam int          V_TOT  = 4;
    localparam int          H_ACT  = 10;
    localparam int          V_ACT  = 3;
    localparam int          FRAME  = H_TOT * V_TOT;
    localparam logic [23:0] BG     = 24'h102030;

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n;
    logic        pixel_de;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic [1:0]  mode;
    logic [15:0] fifo_data = 16'h0000;
    logic        fifo_empty;
    logic        rd_req;
    logic [23:0] pixel_data;
    logic        frame_start;
    logic        underflow;
    logic [7:0]  underflow_cnt;

    logic        pop_d = 1'b0;
    logic [15:0] pop_word;
    logic        obs_rd [FRAME];
    logic [23:0] obs_px [FRAME];
    int          nreq, nfs, npix, cnt;
    int          errs   = 0;
    int          checks = 0;

    always #5 pixel_clk = ~pixel_clk;

    video_window_display #(
        .WIN_X0(3), .WIN_Y0(1), .WIN_W(4), .WIN_H(2),
        .RD_LAT(2), .DATA_W(16), .BG_COLOR(BG)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .pixel_de(pixel_de),
        .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .mode(mode),
        .fifo_data(fifo_data), .fifo_empty(fifo_empty), .rd_req(rd_req),
        .pixel_data(pixel_data), .frame_start(frame_start),
        .underflow(underflow), .underflow_cnt(underflow_cnt)
    );

    // FIFO model: data appears two cycles after the strobe is seen high
    always @(posedge pixel_clk) begin
        pop_d <= rd_req;
        if (pop_d) fifo_data <= pop_word;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic de, input int x, input int y);
        pixel_de   = de;
        pixel_xpos = 11'(x);
        pixel_ypos = 11'(y);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic run_frame(input logic [1:0] m0, input int sw_idx,
                             input logic [1:0] m1, input int empty_idx);
        nreq = 0; nfs = 0; npix = 0;
        for (int k = 0; k < FRAME; k++) begin
            mode       = (k >= sw_idx) ? m1 : m0;
            fifo_empty = (k == empty_idx);
            drive((k % H_TOT < H_ACT) && (k / H_TOT < V_ACT), k % H_TOT, k / H_TOT);
            obs_rd[k] = rd_req;
            obs_px[k] = pixel_data;
            nreq += int'(rd_req);
            nfs  += int'(frame_start);
            if (pixel_data !== BG) npix++;
        end
        fifo_empty = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0; pixel_de = 1'b0; pixel_xpos = 11'd0; pixel_ypos = 11'd0;
        mode = 2'd0; fifo_empty = 1'b0; pop_word = 16'hF800;
        repeat (2) @(posedge pixel_clk);
        #1;
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_pixel", pixel_data, 24'h000000);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_uf", underflow, 1'b0);
        chk("rst_ufcnt", underflow_cnt, 8'd0);
        #2 sys_rst_n = 1'b1;
        drive(1'b1, 3, 1);
        chk("sync_no_read", rd_req, 1'b0);
        drive(1'b0, 11, 3);

        // RGB565 frame: window geometry and latency
        run_frame(2'd0, FRAME, 2'd0, -1);
        chk("f1_fs_count", nfs, 1);
        chk("f1_reads", nreq, 8);
        chk("f1_pix_count", npix, 8);
        chk("f1_rd_x2", obs_rd[14], 1'b0);
        chk("f1_rd_x3", obs_rd[15], 1'b1);
        chk("f1_rd_x6", obs_rd[18], 1'b1);
        chk("f1_rd_x7", obs_rd[19], 1'b0);
        chk("f1_rd_row2", obs_rd[27], 1'b1);
        chk("f1_px_early", obs_px[17], BG);
        chk("f1_px_x3", obs_px[18], 24'hF80000);
        chk("f1_px_x6", obs_px[21], 24'hF80000);
        chk("f1_px_late", obs_px[22], BG);

        // Mode switched to GRAY8 mid-frame: still RGB565 until next frame
        pop_word = 16'h005A;
        run_frame(2'd0, 13, 2'd1, -1);
        chk("midswitch_old_fmt", obs_px[18], 24'h0008D0);
        run_frame(2'd1, FRAME, 2'd1, -1);
        chk("gray_x3", obs_px[18], 24'h5A5A5A);
        chk("gray_last", obs_px[33], 24'h5A5A5A);

        pop_word = 16'h0000;
        run_frame(2'd2, 0, 2'd2, -1);
        chk("bin0_px", obs_px[18], 24'h000000);
        chk("bin0_count", npix, 8);
        pop_word = 16'h0001;
        run_frame(2'd2, 0, 2'd2, -1);
        chk("bin1_px", obs_px[18], 24'hFFFFFF);

        pop_word = 16'h07E0;
        run_frame(2'd3, 0, 2'd3, -1);
        chk("reserved_rgb565", obs_px[18], 24'h00FC00);

        // Underflow on the read of (4,1)
        pop_word = 16'hF800;
        run_frame(2'd0, 0, 2'd0, 17);
        chk("uf_flag", underflow, 1'b1);
        chk("uf_cnt", underflow_cnt, 8'd1);
        chk("uf_reads", nreq, 2);
        chk("uf_pix_count", npix, 2);
        chk("uf_word_shown", obs_px[19], 24'hF80000);
        chk("uf_after_bg", obs_px[20], BG);
        chk("uf_rd_stop", obs_rd[17], 1'b0);
        run_frame(2'd0, 0, 2'd0, -1);
        chk("recover_reads", nreq, 8);
        chk("recover_flag", underflow, 1'b1);
        chk("recover_cnt", underflow_cnt, 8'd1);

        // Underflow coincident with frame start: counted, stays in RUN
        drive(1'b1, 3, 1);
        chk("coinc_rd", rd_req, 1'b1);
        fifo_empty = 1'b1;
        drive(1'b1, 0, 0);
        fifo_empty = 1'b0;
        chk("coinc_cnt", underflow_cnt, 8'd2);
        chk("coinc_fs", frame_start, 1'b1);
        drive(1'b1, 3, 1);
        chk("coinc_run", rd_req, 1'b1);

        // Blanking at (0,0) with de low, then held frame-start condition
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 0, 0);
            cnt += int'(rd_req) + int'(frame_start);
        end
        chk("blank_quiet", cnt, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 0, 0);
            cnt += int'(frame_start);
        end
        chk("held_fs_once", cnt, 1);
        drive(1'b0, 11, 3);

        // Asynchronous reset mid-line
        drive(1'b1, 4, 1);
        chk("pre_rst_rd", rd_req, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_rd", rd_req, 1'b0);
        chk("mid_rst_px", pixel_data, 24'h000000);
        chk("mid_rst_uf", underflow, 1'b0);
        chk("mid_rst_cnt", underflow_cnt, 8'd0);
        #1 sys_rst_n = 1'b1;
        cnt = 0;
        drive(1'b1, 5, 1);
        cnt += int'(rd_req);
        drive(1'b1, 6, 1);
        cnt += int'(rd_req);
        chk("post_rst_no_read", cnt, 0);
        drive(1'b0, 11, 3);
        run_frame(2'd0, 0, 2'd0, -1);
        chk("post_rst_reads", nreq, 8);
        chk("post_rst_fs", nfs, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/video_window_display.md
# video_window_display

Parametrised HDMI pixel-source stage between the frame-buffer read FIFO and the HDMI timing/encoder path. It issues FIFO read requests only for pixels inside a configurable active window. It converts the returned word to 24-bit RGB using a run-time selectable format (RGB565, 8-bit gray, binary edge map) and outputs a background colour elsewhere. It aligns data to coordinates for a parametrised FIFO read latency, and it detects FIFO underflow and recovers at the next frame boundary instead of drifting.

## Interface
Parameters:
- WIN_X0, 0, window left column (inclusive)
- WIN_Y0, 0, window top row (inclusive)
- WIN_W, 1024, window width in pixels
- WIN_H, 720, window height in lines
- RD_LAT, 1, cycles from rd_req high to valid fifo_data (1..4)
- DATA_W, 16, FIFO word width (≥16)
- BG_COLOR, 24'h000000, colour outside window and during resync

Ports:
- pixel_clk  in  1  pixel clock, the only clock
- sys_rst_n  in  1  asynchronous, active-low reset
- pixel_de  in  1  active-video qualifier from the timing generator
- pixel_xpos  in  11  current column
- pixel_ypos  in  11  current row
- mode  in  2  0 RGB565, 1 GRAY8, 2 BINARY, 3 reserved (treated as RGB565)
- fifo_data  in  DATA_W  read data, valid RD_LAT cycles after rd_req
- fifo_empty  in  1  FIFO empty flag
- rd_req  out  1  FIFO read strobe, one word per high cycle
- pixel_data  out  24  RGB888 {R,G,B}
- frame_start  out  1  one-cycle pulse on detected frame start
- underflow  out  1  sticky; set on the first underflow, cleared only by reset
- underflow_cnt  out  8  saturating count of underflow events

## Operation
- in_win = pixel_de && xpos ∈ [WIN_X0, WIN_X0+WIN_W) && ypos ∈ [WIN_Y0, WIN_Y0+WIN_H). Compare in 12-bit arithmetic so the window end cannot wrap.
- fs_cond = pixel_de && xpos==0 && ypos==0. frame_start pulses on the rising edge of fs_cond (registered, so it pulses one cycle after the edge). A held fs_cond gives one pulse.
- State machine:
  - SYNC (reset state): rd_req=0; output BG_COLOR. On the fs_cond rising edge: latch mode into mode_q, go to RUN.
  - RUN: rd_req <= in_win.
    - On a cycle where rd_req==1 and fifo_empty==1: set underflow; increment underflow_cnt, saturating at 255; go to RESYNC.
    - On each fs_cond rising edge: relatch mode_q and stay in RUN.
  - RESYNC: rd_req=0; output BG_COLOR. On the next fs_cond rising edge: latch mode, go to RUN.
- mode changes mid-frame have no effect until the next frame start.
- Format conversion of fifo_data, d = fifo_data:
  - RGB565: {d[15:11],3'b0, d[10:5],2'b0, d[4:0],3'b0}.
  - GRAY8: {d[7:0],d[7:0],d[7:0]}.
  - BINARY: d[DATA_W-1:0]!=0 → 24'hFFFFFF, else 24'h000000.
- Alignment: a valid delay line of length RD_LAT+1 carries "read issued in RUN". On output, valid → converted pixel; otherwise BG_COLOR.
- The word that caused an underflow is still marked valid and outputs whatever fifo_data holds. All later pixels show BG_COLOR until RUN resumes.

## Timing
- Reset (asynchronous assert, synchronous release) forces:
  - rd_req=0, pixel_data=24'h0, frame_start=0, underflow=0, underflow_cnt=0.
  - State SYNC; delay line cleared.
- Coordinates at cycle t:
  - rd_req reflects them at t+1.
  - Data arrives at t+1+RD_LAT.
  - pixel_data is registered at t+2+RD_LAT.
  - Fixed pipeline latency: L = RD_LAT+2.
- Exactly WIN_W rd_req pulses per line and WIN_W×WIN_H per frame in RUN, with no gaps inside a line.
- An fs_cond edge on the same cycle as an underflow detection: underflow is counted, and the state goes to RUN (the new frame wins).
- Reset mid-frame: outputs return to reset values immediately. The first reads occur only after the next frame start.
- A window exceeding the active area is clipped by pixel_de and is not an error.

## Test plan
- RGB565, RD_LAT=1, FIFO never empty, fifo_data=16'hF800 → window pixels 24'hF80000 at latency 3; outside window 24'h000000; 1024 rd_req per line, 737280 per frame.
- GRAY8 with d[7:0]=8'h5A → 24'h5A5A5A. BINARY with d=0 → 24'h000000 and d=1 → 24'hFFFFFF. Change mode mid-frame → output format switches only after the next frame_start pulse.
- WIN_X0=100, WIN_W=200, RD_LAT=3 → first rd_req one cycle after xpos=100, last one cycle after xpos=299; pixel_data for xpos=100 appears 5 cycles after it.
- Force fifo_empty=1 for one cycle at line 10, column 50 → underflow=1, underflow_cnt=1; rd_req low and BG output for the rest of the frame; reads resume after frame_start.
- Hold pixel_de=0 with xpos=ypos=0 through blanking → zero rd_req; one frame_start pulse per frame only.
- Assert sys_rst_n low mid-line → rd_req, pixel_data and the flags are 0 within the same cycle; no rd_req before the next frame start.
